// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmitter and the planned receiver:
// framing mode encodings and an elaboration-time clog2 helper.
package i2s_pkg;

  localparam bit MODE_LJ      = 1'b0;
  localparam bit MODE_PHILIPS = 1'b1;

  // Smallest n with 2**n >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/i2s_bck_gen.sv
// Bit-clock generator: divides the system clock into BCK and flags the
// cycle in which BCK is about to fall, so that serial state moves on that edge.
module i2s_bck_gen
  import i2s_pkg::*;
#(
  parameter int BCK_HALF = 2
) (
  input  logic clock,
  input  logic reset,
  output logic bck,
  output logic fall
);

  localparam int              DIV_W    = clog2(BCK_HALF) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_HALF - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             wrap;

  assign wrap = (div_cnt == DIV_LAST);
  assign fall = wrap & bck;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      div_cnt <= '0;
      bck     <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      bck     <= ~bck;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/i2s_tx_stereo.sv
// Stereo I2S / left-justified master transmitter with a one-frame holding
// buffer, zero-padded slots and selectable underrun behaviour.
module i2s_tx_stereo
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH      = 24,
  parameter int SLOT_WIDTH      = 32,
  parameter int BCK_HALF        = 2,
  parameter bit MODE_I2S        = MODE_PHILIPS,
  parameter bit UNDERRUN_REPEAT = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_left,
  input  logic [DATA_WIDTH-1:0] s_right,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  bck,
  output logic                  lrck,
  output logic                  dat,
  output logic                  frame_start,
  output logic                  underrun
);

  localparam int CNT_W = (clog2(SLOT_WIDTH) > 0) ? clog2(SLOT_WIDTH) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_WIDTH - 1);
  localparam int PAD = SLOT_WIDTH - DATA_WIDTH;

  logic                  fall;
  logic                  slot_end;
  logic                  frame_edge;
  logic [CNT_W-1:0]      bit_cnt;
  logic [SLOT_WIDTH-1:0] shifter;
  logic                  dat_q;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] hold_l, hold_r;
  logic [DATA_WIDTH-1:0] act_l, act_r;
  logic [DATA_WIDTH-1:0] next_l, next_r;

  function automatic logic [SLOT_WIDTH-1:0] align(input logic [DATA_WIDTH-1:0] word);
    return SLOT_WIDTH'(word) << PAD;
  endfunction

  i2s_bck_gen #(
    .BCK_HALF(BCK_HALF)
  ) u_bck_gen (
    .clock(clock),
    .reset(reset),
    .bck  (bck),
    .fall (fall)
  );

  assign slot_end   = (bit_cnt == SLOT_LAST);
  // A slot boundary while lrck is high starts the next (left) frame.
  assign frame_edge = fall & slot_end & lrck;

  // NOTE: every variable gets a default before the branches so the block
  // stays purely combinational.
  always_comb begin
    next_l = '0;
    next_r = '0;
    if (hold_full) begin
      next_l = hold_l;
      next_r = hold_r;
    end else if (UNDERRUN_REPEAT) begin
      next_l = act_l;
      next_r = act_r;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      lrck      <= 1'b1;
      bit_cnt   <= SLOT_LAST;
      shifter   <= '0;
      dat_q     <= 1'b0;
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
      act_l     <= '0;
      act_r     <= '0;
    end else begin
      if (s_valid && !hold_full) begin
        hold_l    <= s_left;
        hold_r    <= s_right;
        hold_full <= 1'b1;
      end
      if (fall) begin
        dat_q <= shifter[SLOT_WIDTH-1];
        if (slot_end) begin
          bit_cnt <= '0;
          lrck    <= ~lrck;
          if (lrck) begin
            act_l   <= next_l;
            act_r   <= next_r;
            shifter <= align(next_l);
            // Only drain a full buffer; an empty one may be filling this cycle.
            if (hold_full) hold_full <= 1'b0;
          end else begin
            shifter <= align(act_r);
          end
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
          shifter <= shifter << 1;
        end
      end
    end
  end

  assign s_ready     = ~hold_full;
  assign dat         = (MODE_I2S == MODE_PHILIPS) ? dat_q : shifter[SLOT_WIDTH-1];
  assign frame_start = frame_edge & reset;
  assign underrun    = frame_edge & reset & ~hold_full;

endmodule

// File: tb/tb_i2s_tx_stereo.sv
// Scoreboard bench for i2s_tx_stereo: one left-justified/repeat instance and
// one default (Philips, zero-on-underrun) instance share the same stimulus.
module tb_i2s_tx_stereo;

  localparam int DW         = 24;
  localparam int SW         = 32;
  localparam int FRAME_CLKS = 256;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] s_left = '0;
  logic [DW-1:0] s_right = '0;
  logic          s_valid = 1'b0;
  logic [1:0]    s_ready, bck, lrck, dat, frame_start, underrun;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  bit in_reset = 1'b1;

  // Index 0: left-justified, repeat on underrun. Index 1: defaults.
  logic [2*DW-1:0] pend  [2][$];
  logic [SW-1:0]   exp_q [2][$];

  logic          prev_bck [2];
  logic          prev_lrck[2];
  logic          slot_lrck[2];
  logic          fs_prev  [2];
  logic          ready_due[2];
  int            nbits    [2];
  int            last_fall[2];
  logic [SW-1:0] acc      [2];
  logic [SW-1:0] tx_prev  [2];
  logic [DW-1:0] last_l   [2];
  logic [DW-1:0] last_r   [2];

  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;

  i2s_tx_stereo #(
    .DATA_WIDTH(DW), .SLOT_WIDTH(SW), .BCK_HALF(2),
    .MODE_I2S(1'b0), .UNDERRUN_REPEAT(1'b1)
  ) dut_lj (
    .clock(clock), .reset(reset), .s_left(s_left), .s_right(s_right),
    .s_valid(s_valid), .s_ready(s_ready[0]), .bck(bck[0]), .lrck(lrck[0]),
    .dat(dat[0]), .frame_start(frame_start[0]), .underrun(underrun[0])
  );

  i2s_tx_stereo dut_i2s (
    .clock(clock), .reset(reset), .s_left(s_left), .s_right(s_right),
    .s_valid(s_valid), .s_ready(s_ready[1]), .bck(bck[1]), .lrck(lrck[1]),
    .dat(dat[1]), .frame_start(frame_start[1]), .underrun(underrun[1])
  );

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Expected slot as captured between lrck edges; Philips mode shifts in
  // the previous slot's last bit first.
  task automatic push_slot(input int i, input logic [DW-1:0] word);
    logic [SW-1:0] w;
    w = SW'(word) << (SW - DW);
    if (i == 1) begin
      exp_q[i].push_back({tx_prev[i][0], w[SW-1:1]});
      tx_prev[i] = w;
    end else begin
      exp_q[i].push_back(w);
    end
  endtask

  task automatic mon_frame(input int i);
    bit            starved;
    logic [DW-1:0] l, r;
    if (ready_due[i]) begin
      check($sformatf("s_ready_after_drain[%0d]", i), s_ready[i], 1);
      ready_due[i] = 1'b0;
    end
    if (frame_start[i]) begin
      starved = (pend[i].size() == 0);
      check($sformatf("underrun[%0d]", i), underrun[i], starved);
      check($sformatf("strobe_bck_lrck[%0d]", i), {bck[i], lrck[i]}, 2'b11);
      if (!starved) begin
        {l, r} = pend[i].pop_front();
        ready_due[i] = 1'b1;
      end else if (i == 0) begin
        l = last_l[i];
        r = last_r[i];
      end else begin
        l = '0;
        r = '0;
      end
      last_l[i] = l;
      last_r[i] = r;
      push_slot(i, l);
      push_slot(i, r);
    end else if (underrun[i]) begin
      check($sformatf("underrun_without_frame[%0d]", i), underrun[i], 0);
    end
    if (prev_lrck[i] && !lrck[i]) begin
      check($sformatf("lrck_fall_follows_frame_start[%0d]", i), fs_prev[i], 1);
      if (last_fall[i] >= 0)
        check($sformatf("lrck_period[%0d]", i), cycle - last_fall[i], FRAME_CLKS);
      last_fall[i] = cycle;
    end
  endtask

  task automatic mon_bits(input int i);
    logic [SW-1:0] want;
    if (bck[i] && !prev_bck[i]) begin
      if (lrck[i] != slot_lrck[i]) begin
        slot_lrck[i] = lrck[i];
        nbits[i]     = 0;
      end
      acc[i] = {acc[i][SW-2:0], dat[i]};
      nbits[i]++;
      if (nbits[i] == SW) begin
        nbits[i] = 0;
        if (exp_q[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL slot_unexpected[%0d]: got %h expected none", i, acc[i]);
        end else begin
          want = exp_q[i].pop_front();
          check($sformatf("slot_%s[%0d]", slot_lrck[i] ? "R" : "L", i), acc[i], want);
        end
      end
    end
  endtask

  // Monitor: samples on the falling system-clock edge, away from updates.
  initial begin
    forever begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        if (in_reset) begin
          pend[i].delete();
          exp_q[i].delete();
          prev_bck[i]  = 1'b0;
          prev_lrck[i] = 1'b1;
          slot_lrck[i] = 1'b1;
          fs_prev[i]   = 1'b0;
          ready_due[i] = 1'b0;
          nbits[i]     = 0;
          last_fall[i] = -1;
          acc[i]       = '0;
          tx_prev[i]   = '0;
          last_l[i]    = '0;
          last_r[i]    = '0;
        end else begin
          mon_frame(i);
          mon_bits(i);
          prev_bck[i]  = bck[i];
          prev_lrck[i] = lrck[i];
          fs_prev[i]   = frame_start[i];
        end
      end
    end
  end

  // Must be called just after a rising edge; returns just after the
  // rising edge on which the frame was accepted.
  task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r,
                      input bit keep_valid);
    int n;
    n       = 0;
    s_left  = l;
    s_right = r;
    s_valid = 1'b1;
    @(negedge clock);
    while (!s_ready[0] && n < 1000) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock);
    if (n < 1000) begin
      pend[0].push_back({l, r});
      pend[1].push_back({l, r});
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no s_ready expected s_ready within 1000 cycles");
    end
    #1;
    if (!keep_valid) s_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_bck[%0d]", tag, i), bck[i], 0);
      check($sformatf("%s_lrck[%0d]", tag, i), lrck[i], 1);
      check($sformatf("%s_dat[%0d]", tag, i), dat[i], 0);
      check($sformatf("%s_s_ready[%0d]", tag, i), s_ready[i], 1);
      check($sformatf("%s_frame_start[%0d]", tag, i), frame_start[i], 0);
      check($sformatf("%s_underrun[%0d]", tag, i), underrun[i], 0);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clock);
    #1;
    check_reset_state("reset");
    reset    = 1'b1;
    in_reset = 1'b0;

    // Idle frame: starved, all-zero data on both instances.
    repeat (300) @(posedge clock);
    #1;

    // Extreme codes: L=0x800001 (MSB and LSB set), R=0x7FFFFF.
    send(24'h800001, 24'h7FFFFF, 1'b0);
    repeat (260) @(posedge clock);
    #1;

    // Back-to-back: s_valid held high across four frames.
    for (int k = 0; k < 4; k++)
      send(24'h010203 + DW'(k * 24'h111111), 24'hF0E0D0 - DW'(k * 24'h010101), k < 3);

    // Starvation after one frame: instance 0 repeats it, instance 1 sends zeros.
    repeat (300) @(posedge clock);
    #1;
    send(24'h123456, 24'hABCDEF, 1'b0);
    repeat (800) @(posedge clock);
    #1;

    // Hold a frame, then reset in the middle of a right slot.
    send(24'hA5A5A5, 24'h5A5A5A, 1'b0);
    n = 0;
    while (lrck[0] && n < 600) begin @(posedge clock); n++; end
    while (!lrck[0] && n < 600) begin @(posedge clock); n++; end
    check("reach_right_slot", n < 600, 1);
    repeat (20) @(posedge clock);
    #1;
    check("hold_full_before_reset", s_ready[0], 0);
    reset    = 1'b0;
    in_reset = 1'b1;
    @(posedge clock);
    #1;
    check_reset_state("midreset");
    repeat (2) @(posedge clock);
    #1;
    reset    = 1'b1;
    in_reset = 1'b0;
    send(24'h3C3C3C, 24'h0F0F0F, 1'b0);
    repeat (600) @(posedge clock);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(10 * 20000);
    $display("FAIL watchdog: got no end of test expected finish within 20000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
